// File: rtl/coreaxitoahbl_pkg.sv
// Shared types and constants for the AXI-to-AHB-Lite write-buffer fill path.
package coreaxitoahbl_pkg;

    localparam int AXI_LEN_W    = 8;
    localparam int DRAIN_CYCLES = 2;

    // Drain timer is a down-counter loaded with DRAIN_CYCLES-1; READY at terminal count zero.
    localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } wbuf_state_e;

endpackage

// File: rtl/coreaxitoahbl_wbuf_beat_cnt.sv
// Beat counter for one write burst: clear/increment, with last-beat and
// buffer-overflow compares against the latched burst length and RAM depth.
module coreaxitoahbl_wbuf_beat_cnt
    import coreaxitoahbl_pkg::*;
#(
    parameter int AXI_LWIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  inc_i,
    input  logic [AXI_LEN_W-1:0]  len_i,
    output logic [AXI_LWIDTH-1:0] addr_o,
    output logic                  last_o,
    output logic                  ovf_o
);

    // One extra bit so a depth of 256 (AXI_LWIDTH=8) is representable.
    localparam logic [AXI_LEN_W:0] DEPTH_CMP = (AXI_LEN_W + 1)'(2 ** AXI_LWIDTH);

    logic [AXI_LEN_W-1:0] cnt_q;
    logic [AXI_LEN_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign addr_o = cnt_q[AXI_LWIDTH-1:0];
    assign last_o = (cnt_q == len_i);
    assign ovf_o  = ({1'b0, cnt_q} >= DEPTH_CMP);

endmodule

// File: rtl/coreaxitoahbl_wbuf_fill_ctrl.sv
// Write-side fill controller for the AXI-to-AHB-Lite write-data buffer.
// Optional build macro COREAXITOAHBL_WLAST_CHK_EN adds the sticky wlastErr output.
//
// state | meaning
// IDLE  | waiting for burstStart; WREADY low
// LOAD  | accepting W beats, writing buffer until count reaches latched length
// DRAIN | waiting out the buffer write register and RAM write
// READY | burst resident; bufReady high until bufRelease
module coreaxitoahbl_wbuf_fill_ctrl
    import coreaxitoahbl_pkg::*;
#(
    parameter int AXI_DWIDTH = 64,
    parameter int AXI_LWIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  burstStart,
    input  logic [AXI_LEN_W-1:0]  burstLen,
    input  logic                  WVALID,
    input  logic [AXI_DWIDTH-1:0] WDATA,
    input  logic                  WLAST,
    output logic                  WREADY,
    output logic                  wrEn,
    output logic [AXI_LWIDTH-1:0] wrAddr,
    output logic [AXI_DWIDTH-1:0] wrData,
    output logic                  bufReady,
    output logic [AXI_LEN_W-1:0]  bufBeats,
    output logic                  ovfErr,
    input  logic                  bufRelease
`ifdef COREAXITOAHBL_WLAST_CHK_EN
    ,
    output logic                  wlastErr
`endif
);

    wbuf_state_e           state_q, state_d;
    logic [AXI_LEN_W-1:0]  len_q, len_d;
    logic [1:0]            drain_q, drain_d;
    logic                  wr_en_q, wr_en_d;
    logic [AXI_LWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [AXI_DWIDTH-1:0] wr_data_q, wr_data_d;
    logic                  ovf_q, ovf_d;

    logic                  beat;
    logic                  cnt_clr;
    logic [AXI_LWIDTH-1:0] cnt_addr;
    logic                  cnt_last;
    logic                  cnt_ovf;

    assign beat    = WVALID && (state_q == LOAD);
    assign cnt_clr = (state_q == IDLE) && burstStart;

    coreaxitoahbl_wbuf_beat_cnt #(
        .AXI_LWIDTH (AXI_LWIDTH)
    ) u_beat_cnt (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .clr_i  (cnt_clr),
        .inc_i  (beat),
        .len_i  (len_q),
        .addr_o (cnt_addr),
        .last_o (cnt_last),
        .ovf_o  (cnt_ovf)
    );

`ifdef COREAXITOAHBL_WLAST_CHK_EN
    logic wlast_err_q, wlast_err_d;
`else
    logic unused_wlast;
    assign unused_wlast = WLAST;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        drain_d   = drain_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q;
`ifdef COREAXITOAHBL_WLAST_CHK_EN
        wlast_err_d = wlast_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (burstStart) begin
                    len_d   = burstLen;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    // Beats past the RAM depth are still accepted so AXI never stalls.
                    if (cnt_ovf) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_addr;
                        wr_data_d = WDATA;
                    end
`ifdef COREAXITOAHBL_WLAST_CHK_EN
                    if (WLAST != cnt_last) begin
                        wlast_err_d = 1'b1;
                    end
`endif
                    if (cnt_last) begin
                        drain_d = DRAIN_LOAD;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = READY;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            READY: begin
                if (bufRelease) begin
                    ovf_d   = 1'b0;
`ifdef COREAXITOAHBL_WLAST_CHK_EN
                    wlast_err_d = 1'b0;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            len_q     <= '0;
            drain_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            drain_q   <= drain_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef COREAXITOAHBL_WLAST_CHK_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wlast_err_q <= 1'b0;
        end else begin
            wlast_err_q <= wlast_err_d;
        end
    end

    assign wlastErr = wlast_err_q;
`endif

    assign WREADY   = (state_q == LOAD);
    assign wrEn     = wr_en_q;
    assign wrAddr   = wr_addr_q;
    assign wrData   = wr_data_q;
    assign bufReady = (state_q == READY);
    assign bufBeats = (state_q == READY) ? len_q : '0;
    assign ovfErr   = ovf_q;

endmodule
